// File: rtl/pipeline_sequencer_pkg.sv
// Shared types, PC-source encodings and parameter checks for the pipeline sequencer.
package pipeline_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBoot  = 2'b01,
      StRun   = 2'b10,
      StDrain = 2'b11
   } state_e;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_RESET  = 2'b01;
   localparam logic [1:0] PC_BRANCH = 2'b10;

   function automatic bit params_legal(input int unsigned num_stages,
                                       input int unsigned exec_stage,
                                       input int unsigned resolve_stage);
      return (num_stages >= 3) && (num_stages <= 16) && (exec_stage > 0) &&
             (exec_stage <= resolve_stage) && (resolve_stage < num_stages);
   endfunction

   function automatic logic [4:0] count_ones(input logic [15:0] vec);
      logic [4:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         cnt = cnt + 5'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/pipe_valid_chain.sv
// Per-stage valid token shift register with hold, single-stage bubble insert and flush mask.
module pipe_valid_chain #(
   parameter int unsigned NUM_STAGES   = 6,
   parameter int unsigned BUBBLE_STAGE = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_STAGES-1:0] stage_en,
   input  logic                  inject,
   input  logic                  bubble,
   input  logic [NUM_STAGES-1:0] flush_mask,
   output logic [NUM_STAGES-1:0] valid
);

   logic [NUM_STAGES-1:0] valid_q, valid_d, shifted;

   always_comb begin
      shifted = {valid_q[NUM_STAGES-2:0], inject};
      if (bubble) shifted[BUBBLE_STAGE] = 1'b0;
      // Flush overrides hold so a cleared stage can never keep a stale token.
      valid_d = ((stage_en & shifted) | (~stage_en & valid_q)) & ~flush_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   assign valid = valid_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control: boot/run/drain FSM, stall and flush steering, saturating bubble counter.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES    = 6,
   parameter int unsigned EXEC_STAGE    = 2,
   parameter int unsigned RESOLVE_STAGE = 3,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  hazard_req,
   input  logic                  branch_taken,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  load_pc,
   output logic [1:0]            sel_pc,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      bubble_count
);

   if (!params_legal(NUM_STAGES, EXEC_STAGE, RESOLVE_STAGE)) begin : g_param_check
      $error("pipeline_sequencer: illegal stage parameters");
   end

   localparam int unsigned SumW = ((CNT_W > 5) ? CNT_W : 5) + 1;
   localparam logic [SumW-1:0] CntMax = SumW'({CNT_W{1'b1}});

   state_e                state_q, state_d;
   logic                  run, active, branch, hazard, inject;
   logic [NUM_STAGES-1:0] flush_mask;
   logic [15:0]           flush_src;
   logic [4:0]            add;
   logic [SumW-1:0]       sum;
   logic [CNT_W-1:0]      count_q, count_d;

   always_comb begin
      run    = (state_q == StRun);
      active = run || (state_q == StDrain);
      branch = active && branch_taken && stage_valid[RESOLVE_STAGE];
      hazard = active && hazard_req && stage_valid[EXEC_STAGE] && !branch;
      inject = run && !halt_req;

      stage_en = '0;
      if (active) begin
         stage_en = '1;
         if (hazard) begin
            for (int unsigned i = 0; i <= EXEC_STAGE; i++) stage_en[i] = 1'b0;
         end
      end

      load_pc = 1'b0;
      sel_pc  = PC_SEQ;
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StBoot;
         StBoot: begin
            load_pc = 1'b1;
            sel_pc  = PC_RESET;
            state_d = StRun;
         end
         StRun: begin
            if (branch) begin
               load_pc = 1'b1;
               sel_pc  = PC_BRANCH;
            end else begin
               load_pc = !halt_req && !hazard;
            end
            if (halt_req) state_d = StDrain;
         end
         StDrain: if (stage_valid == '0) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      flush_mask = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         flush_mask[i] = branch && (i <= RESOLVE_STAGE);
      end

      // Only tokens younger than the branch are lost; the branch itself moves on.
      flush_src = '0;
      for (int unsigned i = 0; i < RESOLVE_STAGE; i++) flush_src[i] = stage_valid[i];

      add     = branch ? count_ones(flush_src) : {4'b0, hazard};
      sum     = SumW'(count_q) + SumW'(add);
      count_d = (sum > CntMax) ? '1 : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   pipe_valid_chain #(
      .NUM_STAGES  (NUM_STAGES),
      .BUBBLE_STAGE(EXEC_STAGE + 1)
   ) u_valid_chain (
      .clk       (clk),
      .rst_n     (rst_n),
      .stage_en  (stage_en),
      .inject    (inject),
      .bubble    (hazard),
      .flush_mask(flush_mask),
      .valid     (stage_valid)
   );

   assign state        = state_q;
   assign bubble_count = count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; a second narrow-counter instance covers saturation.
module tb_pipeline_sequencer;

   localparam int unsigned N = 6;

   logic         clk, rst_n, start, halt_req, hazard_req, branch_taken;
   logic [N-1:0] stage_valid, stage_en;
   logic         load_pc;
   logic [1:0]   sel_pc, state;
   logic [15:0]  bubble_count;

   logic [N-1:0] s_stage_valid, s_stage_en;
   logic         s_load_pc;
   logic [1:0]   s_sel_pc, s_state;
   logic [1:0]   s_bubble_count;

   int checks = 0;
   int errors = 0;

   pipeline_sequencer #(
      .NUM_STAGES(N), .EXEC_STAGE(2), .RESOLVE_STAGE(3), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .hazard_req(hazard_req), .branch_taken(branch_taken),
      .stage_valid(stage_valid), .stage_en(stage_en), .load_pc(load_pc),
      .sel_pc(sel_pc), .state(state), .bubble_count(bubble_count)
   );

   pipeline_sequencer #(
      .NUM_STAGES(N), .EXEC_STAGE(2), .RESOLVE_STAGE(3), .CNT_W(2)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .hazard_req(hazard_req), .branch_taken(branch_taken),
      .stage_valid(s_stage_valid), .stage_en(s_stage_en), .load_pc(s_load_pc),
      .sel_pc(s_sel_pc), .state(s_state), .bubble_count(s_bubble_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic check_cnt(input logic [15:0] exp);
      check("bubble_count", 32'(bubble_count), 32'(exp));
      check("bubble_count_sat", 32'(s_bubble_count), (exp > 16'd3) ? 32'd3 : 32'(exp));
   endtask

   task automatic fill_check(input int cycles);
      for (int k = 1; k <= cycles; k++) cycle();
      check("refill_valid", 32'(stage_valid), 32'h3F);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; hazard_req = 1'b0; branch_taken = 1'b0;
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_valid", 32'(stage_valid), 32'd0);
      check("rst_en", 32'(stage_en), 32'd0);
      check("rst_load_pc", 32'(load_pc), 32'd0);
      check("rst_sel_pc", 32'(sel_pc), 32'd0);
      check_cnt(16'd0);
      rst_n = 1'b1;

      // Boot and fill
      cycle();
      start = 1'b1;
      #1;
      check("idle_before_edge", 32'(state), 32'd0);
      cycle();
      start = 1'b0;
      check("boot_state", 32'(state), 32'd1);
      check("boot_load_pc", 32'(load_pc), 32'd1);
      check("boot_sel_pc", 32'(sel_pc), 32'd1);
      check("boot_valid", 32'(stage_valid), 32'd0);
      cycle();
      check("run_state", 32'(state), 32'd2);
      check("run_en", 32'(stage_en), 32'h3F);
      check("run_load_pc", 32'(load_pc), 32'd1);
      check("run_sel_pc", 32'(sel_pc), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         check("fill_valid", 32'(stage_valid), (32'd1 << k) - 32'd1);
      end

      // Two-cycle load-use hazard
      hazard_req = 1'b1;
      #1;
      check("haz1_en", 32'(stage_en), 32'h38);
      check("haz1_load_pc", 32'(load_pc), 32'd0);
      cycle();
      check("haz1_valid", 32'(stage_valid), 32'h37);
      check("haz2_en", 32'(stage_en), 32'h38);
      check("haz2_load_pc", 32'(load_pc), 32'd0);
      check_cnt(16'd1);
      cycle();
      hazard_req = 1'b0;
      #1;
      check("haz2_valid", 32'(stage_valid), 32'h27);
      check_cnt(16'd2);
      fill_check(3);

      // Taken branch on a full pipe
      branch_taken = 1'b1;
      #1;
      check("br_sel_pc", 32'(sel_pc), 32'd2);
      check("br_load_pc", 32'(load_pc), 32'd1);
      check("br_en", 32'(stage_en), 32'h3F);
      cycle();
      branch_taken = 1'b0;
      #1;
      check("br_valid", 32'(stage_valid), 32'h30);
      check("br_state", 32'(state), 32'd2);
      check_cnt(16'd5);

      // Asynchronous reset mid-run
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(stage_valid), 32'd0);
      check("arst_state", 32'(state), 32'd0);
      check("arst_en", 32'(stage_en), 32'd0);
      check("arst_load_pc", 32'(load_pc), 32'd0);
      check_cnt(16'd0);
      rst_n = 1'b1;
      cycle();
      check("arst_stays_idle", 32'(state), 32'd0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("reboot_state", 32'(state), 32'd1);
      cycle();
      fill_check(6);

      // Branch and hazard together: branch wins
      branch_taken = 1'b1;
      hazard_req = 1'b1;
      #1;
      check("brhz_en", 32'(stage_en), 32'h3F);
      check("brhz_sel_pc", 32'(sel_pc), 32'd2);
      check("brhz_load_pc", 32'(load_pc), 32'd1);
      cycle();
      check("brhz_valid", 32'(stage_valid), 32'h30);
      check_cnt(16'd3);

      // Requests while their qualifying stages are empty are ignored
      check("unq_en", 32'(stage_en), 32'h3F);
      check("unq_load_pc", 32'(load_pc), 32'd1);
      check("unq_sel_pc", 32'(sel_pc), 32'd0);
      cycle();
      branch_taken = 1'b0;
      hazard_req = 1'b0;
      check("unq_valid", 32'(stage_valid), 32'h21);
      check_cnt(16'd3);
      fill_check(5);

      // Halt and drain; start must be ignored while draining
      halt_req = 1'b1;
      #1;
      check("halt_load_pc", 32'(load_pc), 32'd0);
      check("halt_en", 32'(stage_en), 32'h3F);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         start = 1'b1;
         #1;
         check("drain_valid", 32'(stage_valid), (32'h3F << k) & 32'h3F);
         check("drain_state", 32'(state), 32'd3);
         check("drain_load_pc", 32'(load_pc), 32'd0);
      end
      cycle();
      start = 1'b0;
      halt_req = 1'b0;
      #1;
      check("drain_idle", 32'(state), 32'd0);
      check("idle_en", 32'(stage_en), 32'd0);
      check("idle_load_pc", 32'(load_pc), 32'd0);
      cycle();
      check("idle_hold", 32'(state), 32'd0);
      check_cnt(16'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
